// File: rtl/vscale_alu_arbiter.sv
// Shares one combinational vscale ALU between the integer pipeline (port 0) and a secondary
// unit (port 1). Port 0 has fixed priority; a saturating counter bounds port-1 starvation.
module vscale_alu_arbiter #(
  parameter int unsigned XPR_LEN      = 32,
  parameter int unsigned OP_W         = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [OP_W-1:0]    req0_op,
  input  logic [XPR_LEN-1:0] req0_in1,
  input  logic [XPR_LEN-1:0] req0_in2,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [OP_W-1:0]    req1_op,
  input  logic [XPR_LEN-1:0] req1_in1,
  input  logic [XPR_LEN-1:0] req1_in2,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic [XPR_LEN-1:0] resp0_data,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [XPR_LEN-1:0] resp1_data,
  output logic [OP_W-1:0]    alu_op,
  output logic [XPR_LEN-1:0] alu_in1,
  output logic [XPR_LEN-1:0] alu_in2,
  input  logic [XPR_LEN-1:0] alu_out
);

  localparam int unsigned    CntW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);
  localparam logic [OP_W-1:0] AluOpAdd  = '0;

  logic               elig0, elig1;
  logic               grant0, grant1;
  logic [CntW-1:0]    starve_cnt_d, starve_cnt_q;
  logic               resp0_valid_d, resp0_valid_q;
  logic               resp1_valid_d, resp1_valid_q;
  logic [XPR_LEN-1:0] resp0_data_d, resp0_data_q;
  logic [XPR_LEN-1:0] resp1_data_d, resp1_data_q;

  // A full response slot may still issue if it is being drained this same cycle.
  always_comb begin
    elig0  = req0_valid && (!resp0_valid_q || resp0_ready);
    elig1  = req1_valid && (!resp1_valid_q || resp1_ready);
    grant1 = reset_n && elig1 && ((starve_cnt_q == StarveMax) || !elig0);
    grant0 = reset_n && elig0 && !grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_op  = AluOpAdd;
    alu_in1 = '0;
    alu_in2 = '0;
    if (grant0) begin
      alu_op  = req0_op;
      alu_in1 = req0_in1;
      alu_in2 = req0_in2;
    end else if (grant1) begin
      alu_op  = req1_op;
      alu_in1 = req1_in1;
      alu_in2 = req1_in2;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant1 || !elig1) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    resp0_valid_d = resp0_valid_q;
    resp0_data_d  = resp0_data_q;
    if (grant0) begin
      resp0_valid_d = 1'b1;
      resp0_data_d  = alu_out;
    end else if (resp0_valid_q && resp0_ready) begin
      resp0_valid_d = 1'b0;
    end
  end

  always_comb begin
    resp1_valid_d = resp1_valid_q;
    resp1_data_d  = resp1_data_q;
    if (grant1) begin
      resp1_valid_d = 1'b1;
      resp1_data_d  = alu_out;
    end else if (resp1_valid_q && resp1_ready) begin
      resp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q  <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_data_q  <= resp1_data_d;
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_data  = resp0_data_q;
  assign resp1_data  = resp1_data_q;

endmodule

// File: tb/tb_vscale_alu_arbiter.sv
// Directed bench for vscale_alu_arbiter; a small ALU stand-in closes the combinational loop.
module tb_vscale_alu_arbiter;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSlt = 4'd2;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpSub = 4'd10;
  localparam logic [3:0] OpSra = 4'd11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp0_data, resp1_data, alu_in1, alu_in2, alu_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      4'd0:    alu_out = alu_in1 + alu_in2;
      4'd2:    alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
      4'd4:    alu_out = alu_in1 ^ alu_in2;
      4'd10:   alu_out = alu_in1 - alu_in2;
      4'd11:   alu_out = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
      default: alu_out = '0;
    endcase
  end

  vscale_alu_arbiter #(.XPR_LEN(32), .OP_W(4), .STARVE_LIMIT(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .resp0_valid(resp0_valid),
    .resp0_ready(resp0_ready),
    .resp0_data (resp0_data),
    .resp1_valid(resp1_valid),
    .resp1_ready(resp1_ready),
    .resp1_data (resp1_data),
    .alu_op     (alu_op),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_out    (alu_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    req0_valid = v;
    req0_op    = op;
    req0_in1   = a;
    req0_in2   = b;
  endtask

  task automatic drv1(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    req1_valid = v;
    req1_op    = op;
    req1_in1   = a;
    req1_in2   = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    drv0(1'b1, OpAdd, 32'd5, 32'd7);
    drv1(1'b1, OpAdd, 32'd1, 32'd1);
    #12;
    check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    check("rst_resp0_valid", {31'b0, resp0_valid}, 32'd0);
    check("rst_resp1_valid", {31'b0, resp1_valid}, 32'd0);
    check("rst_resp0_data", resp0_data, 32'd0);
    check("rst_resp1_data", resp1_data, 32'd0);

    // Idle
    drv0(1'b0, OpSub, 32'd9, 32'd9);
    drv1(1'b0, OpXor, 32'd9, 32'd9);
    reset_n = 1'b1;
    #1;
    check("idle_alu_op", {28'b0, alu_op}, 32'd0);
    check("idle_alu_in1", alu_in1, 32'd0);
    check("idle_alu_in2", alu_in2, 32'd0);
    check("idle_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("idle_req1_ready", {31'b0, req1_ready}, 32'd0);
    step();
    check("idle_resp0_valid", {31'b0, resp0_valid}, 32'd0);
    check("idle_resp1_valid", {31'b0, resp1_valid}, 32'd0);

    // Single op: ADD 5+7
    drv0(1'b1, OpAdd, 32'd5, 32'd7);
    #1;
    check("single_req0_ready", {31'b0, req0_ready}, 32'd1);
    check("single_alu_in1", alu_in1, 32'd5);
    step();
    drv0(1'b0, OpAdd, 32'd0, 32'd0);
    check("single_resp0_valid", {31'b0, resp0_valid}, 32'd1);
    check("single_resp0_data", resp0_data, 32'd12);
    step();
    check("single_resp0_drained", {31'b0, resp0_valid}, 32'd0);

    // Starvation: grant pattern 0,0,0,1 repeating
    drv0(1'b1, OpAdd, 32'd1, 32'd2);
    drv1(1'b1, OpSub, 32'd10, 32'd3);
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("starve_req1_ready_%0d", i), {31'b0, req1_ready}, {31'b0, (i % 4) == 3});
      check($sformatf("starve_req0_ready_%0d", i), {31'b0, req0_ready}, {31'b0, (i % 4) != 3});
      step();
      if ((i % 4) == 3) check($sformatf("starve_resp1_data_%0d", i), resp1_data, 32'd7);
      else check($sformatf("starve_resp0_data_%0d", i), resp0_data, 32'd3);
    end
    drv0(1'b0, OpAdd, 32'd0, 32'd0);
    drv1(1'b0, OpAdd, 32'd0, 32'd0);
    step();
    check("starve_resp0_drained", {31'b0, resp0_valid}, 32'd0);
    check("starve_resp1_drained", {31'b0, resp1_valid}, 32'd0);

    // Backpressure isolation
    drv0(1'b1, OpSlt, 32'hFFFF_FFFF, 32'd1);
    step();
    check("bp_slt_data", resp0_data, 32'd1);
    resp0_ready = 1'b0;
    drv0(1'b1, OpSlt, 32'd5, 32'd1);
    drv1(1'b1, OpXor, 32'h0000_00F0, 32'h0000_00FF);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("bp_req0_ready_%0d", i), {31'b0, req0_ready}, 32'd0);
      check($sformatf("bp_req1_ready_%0d", i), {31'b0, req1_ready}, 32'd1);
      step();
      check($sformatf("bp_resp0_data_%0d", i), resp0_data, 32'd1);
      check($sformatf("bp_resp0_valid_%0d", i), {31'b0, resp0_valid}, 32'd1);
      check($sformatf("bp_resp1_data_%0d", i), resp1_data, 32'h0000_000F);
    end

    // Drain and issue on port 0 in the same cycle
    drv1(1'b0, OpAdd, 32'd0, 32'd0);
    resp0_ready = 1'b1;
    drv0(1'b1, OpSra, 32'h8000_0000, 32'd4);
    #1;
    check("di_req0_ready", {31'b0, req0_ready}, 32'd1);
    step();
    check("di_resp0_valid", {31'b0, resp0_valid}, 32'd1);
    check("di_resp0_data", resp0_data, 32'hF800_0000);
    drv0(1'b0, OpAdd, 32'd0, 32'd0);
    step();
    check("di_resp0_drained", {31'b0, resp0_valid}, 32'd0);

    // Reset while port 1 holds a result
    drv1(1'b1, OpSub, 32'd10, 32'd3);
    step();
    drv1(1'b0, OpAdd, 32'd0, 32'd0);
    resp1_ready = 1'b0;
    check("rst1_pre_resp1_valid", {31'b0, resp1_valid}, 32'd1);
    check("rst1_pre_resp1_data", resp1_data, 32'd7);
    #3 reset_n = 1'b0;
    #1;
    check("rst1_resp1_valid", {31'b0, resp1_valid}, 32'd0);
    check("rst1_resp1_data", resp1_data, 32'd0);
    #2 reset_n = 1'b1;
    step();

    // Reset with starvation count at 2; the full wait must restart afterwards
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    drv0(1'b1, OpAdd, 32'd1, 32'd2);
    drv1(1'b1, OpSub, 32'd10, 32'd3);
    step();
    step();
    check("rst2_pre_resp0_valid", {31'b0, resp0_valid}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("rst2_resp0_valid", {31'b0, resp0_valid}, 32'd0);
    check("rst2_resp0_data", resp0_data, 32'd0);
    check("rst2_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst2_req1_ready", {31'b0, req1_ready}, 32'd0);
    #2 reset_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst2_req1_ready_%0d", i), {31'b0, req1_ready}, {31'b0, i == 3});
      step();
    end
    drv0(1'b0, OpAdd, 32'd0, 32'd0);
    drv1(1'b0, OpAdd, 32'd0, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vscale_alu_arbiter.md
# vscale_alu_arbiter

Shares one combinational vscale ALU between two requesters: port 0, the integer pipeline, and port 1, a secondary unit such as a CSR or debug engine. The block arbitrates each cycle with fixed port-0 priority plus a starvation limit for port 1. It drives the granted operands into the ALU and captures the result in a per-port response register. Each response register has its own valid/ready handshake.

## Interface
- `XPR_LEN`, 32, operand/result width
- `OP_W`, 4, ALU op width (`ALU_OP_WIDTH`)
- `STARVE_LIMIT`, 3, max consecutive cycles an eligible port 1 may be denied (≥1)
- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle (= grant)
- `req0_op`, `req1_op`  in  OP_W  ALU op code
- `req0_in1`, `req0_in2`, `req1_in1`, `req1_in2`  in  XPR_LEN  operands
- `resp0_valid`, `resp1_valid`  out  1  result held
- `resp0_ready`, `resp1_ready`  in  1  consumer takes result
- `resp0_data`, `resp1_data`  out  XPR_LEN  result
- `alu_op`  out  OP_W  to ALU `op`
- `alu_in1`, `alu_in2`  out  XPR_LEN  to ALU `in1`/`in2`
- `alu_out`  in  XPR_LEN  from ALU `out` (combinational)

## Operation
- Eligibility: `eligK = reqK_valid && (!respK_valid || respK_ready)`. A port whose response slot is full and not draining this cycle cannot issue.
- Grant, computed combinationally each cycle:
  - If `elig1` and `starve_cnt == STARVE_LIMIT`, grant 1.
  - Otherwise, if `elig0`, grant 0.
  - Otherwise, if `elig1`, grant 1.
  - Otherwise, no grant.
  - At most one grant per cycle.
- `reqK_ready = grantK`. Ready may depend on valid and on `respK_ready`, so requesters must not make valid depend on ready.
- ALU mux:
  - A granted port's op and operands drive `alu_op`/`alu_in1`/`alu_in2`.
  - With no grant, the mux drives `ALU_OP_ADD` with zero operands.
- Response register K:
  - On `grantK`: `respK_data <= alu_out`, `respK_valid <= 1`.
  - Else, if `respK_valid && respK_ready`: `respK_valid <= 0`, data unchanged.
  - Else: hold.
- Same-cycle drain and issue on one port: the old result is consumed, the new one is loaded, and valid stays 1.
- `starve_cnt`, width clog2(STARVE_LIMIT+1):
  - Clears when `grant1` or `!elig1`.
  - Increments when `elig1 && !grant1`.
  - Saturates at STARVE_LIMIT.
- Ports are independent:
  - Backpressure on resp0 never blocks port 1, and vice versa.
  - Results are never reordered within a port (single entry per port).
- Unknown op codes pass through unchanged; the ALU yields 0.

## Timing
- Latency: request accepted in cycle N gives `respK_valid` high in cycle N+1, with the result of the cycle-N operands.
- Throughput per port: one op per cycle while `respK_ready` stays high.
- Aggregate throughput: one op per cycle total.
- Worst-case port-1 wait while eligible: STARVE_LIMIT denied cycles, then a grant in the next cycle.
- Reset (`reset_n` low, asynchronous assert):
  - `resp0_valid = resp1_valid = 0`, `resp0_data = resp1_data = 0`, `starve_cnt = 0`.
  - `req*_ready` evaluate to 0 while reset is asserted.
  - Requests in flight when reset asserts are dropped, with no partial response.
- Reset deassertion: the first grant is possible in the first rising edge after release.
- `respK_data` is stable while `respK_valid && !respK_ready`.

## Test plan
- Single op: port 0 sends ADD 5+7 with resp0_ready=1 → req0_ready=1 in cycle 0; resp0_valid=1 with resp0_data=12 in cycle 1; resp0_valid=0 in cycle 2 if no new request.
- Starvation: both ports valid continuously, both resp_ready=1, STARVE_LIMIT=3 → grant sequence 0,0,0,1,0,0,0,1,…; port 1 SUB 10-3 returns 7.
- Backpressure isolation: resp0_ready=0 after one port-0 SLT(-1,1) → resp0_data=1 held, req0_ready=0, and port 1 XOR 0xF0^0xFF is granted every cycle, returning 0x0F.
- Drain+issue: resp0_valid=1, resp0_ready=1, and a new port-0 SRA 0x80000000>>4 in the same cycle → req0_ready=1, resp0_valid stays 1, next resp0_data=0xF8000000.
- Reset mid-operation: reset_n pulled low asynchronously while resp1_valid=1 and starve_cnt=2 → resp*_valid=0, data=0, starve_cnt=0 immediately; after release the first port-1 grant waits the full STARVE_LIMIT again.
- Idle: no valids → alu_op=ALU_OP_ADD, alu_in1=alu_in2=0, req*_ready=0, no response state change.
